proc_control: RTL

- Control-unit FSM for the 16-bit datapath.
- Decodes the 9-bit instruction register (III XXX YYY) and steps through time slots T0..T3.
- Each cycle it drives the select/enable lines of the bus multiplexer (Rout one-hot, Gout, DINout) and the register load enables (IRin, Rin, Ain, Gin), plus AddSub and Done.
- Sits between the IR register and the bus mux/register file/ALU inside the processor top.

---
 rtl/proc_control.sv | 113 +++++++++++
 1 files changed

// File: rtl/proc_control.sv
// Control FSM for the 16-bit datapath: walks T0..T3 and decodes IR into bus-select and load enables.
// Outputs are combinational from the slot register, IR and Run; no backpressure (Run is a level request sampled in T0).
module proc_control (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Run,
    input  logic [8:0] IR,
    output logic       IRin,
    output logic [7:0] Rout,
    output logic [7:0] Rin,
    output logic       Gout,
    output logic       DINout,
    output logic       Ain,
    output logic       Gin,
    output logic       AddSub,
    output logic       Done,
    output logic [1:0] Tstep
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_e;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    tstep_e     tstep_q;
    tstep_e     tstep_d;
    logic [2:0] opcode;
    logic [7:0] x_sel;
    logic [7:0] y_sel;
    logic       is_arith;

    assign opcode   = IR[8:6];
    assign x_sel    = 8'h80 >> IR[5:3];
    assign y_sel    = 8'h80 >> IR[2:0];
    assign is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);
    assign Tstep    = tstep_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            tstep_q <= T0;
        end else begin
            tstep_q <= tstep_d;
        end
    end

    always_comb begin
        tstep_d = T0;
        IRin    = 1'b0;
        Rout    = 8'h00;
        Rin     = 8'h00;
        Gout    = 1'b0;
        DINout  = 1'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        AddSub  = 1'b0;
        Done    = 1'b0;
        case (tstep_q)
            T0: begin
                IRin    = Run;
                tstep_d = Run ? T1 : T0;
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        Rout = y_sel;
                        Rin  = x_sel;
                        Done = 1'b1;
                    end
                    OP_MVI: begin
                        DINout = 1'b1;
                        Rin    = x_sel;
                        Done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        Rout    = x_sel;
                        Ain     = 1'b1;
                        tstep_d = T2;
                    end
                    default: begin
                        Done = 1'b1;
                    end
                endcase
            end
            // An IR that changed under an add/sub in flight drops back to T0 with everything idle.
            T2: begin
                if (is_arith) begin
                    Rout    = y_sel;
                    Gin     = 1'b1;
                    AddSub  = (opcode == OP_SUB);
                    tstep_d = T3;
                end
            end
            T3: begin
                if (is_arith) begin
                    Gout = 1'b1;
                    Rin  = x_sel;
                    Done = 1'b1;
                end
            end
            default: begin
                tstep_d = T0;
            end
        endcase
    end

endmodule
